// File: rtl/rx_frame_parser.sv
// Ethernet RX parser: header capture, DA filter, payload write into brx.
// Optional RX_STATS_EN adds saturating good/drop/err frame counters.
module rx_frame_parser #(
  parameter int          SIZE      = 2048,
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter int          CW        = $clog2(SIZE+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_tdata,
  input  logic          rx_tvalid,
  input  logic          rx_tlast,
  input  logic          rx_tuser,
  output logic          rx_tready,
  input  logic          brx_full,
  output logic          brx_wr_en,
  output logic [7:0]    brx_wr_data,
  output logic          brx_frame_end,
  output logic          brx_frame_bad,
  output logic [47:0]   rx_dst_mac,
  output logic [47:0]   rx_src_mac,
  output logic [15:0]   rx_len_type,
  output logic          rx_header_valid,
  output logic [CW-1:0] payload_len
`ifdef RX_STATS_EN
  ,
  output logic [15:0]   stat_good,
  output logic [15:0]   stat_drop,
  output logic [15:0]   stat_err
`endif
);

  typedef enum logic [1:0] {
    IDLE, HEADER, PAYLOAD, DROP
  } state_e;

  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  state_e        state_q, state_d;
  logic [3:0]    hcnt_q, hcnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          ovf_q, ovf_d;
  logic [47:0]   dst_q, dst_d;
  logic [47:0]   src_q, src_d;
  logic [15:0]   lt_q, lt_d;
  logic          hv_q, hv_d;
  logic          fend_q, fend_d;
  logic          fbad_q, fbad_d;
  logic [CW-1:0] plen_q, plen_d;
  logic          drop_evt;
  logic          beat;
  logic          match;

  assign beat  = rx_tvalid & rx_tready;
  assign match = (dst_q == LOCAL_MAC) || (dst_q == '1);

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    ovf_d       = ovf_q;
    dst_d       = dst_q;
    src_d       = src_q;
    lt_d        = lt_q;
    hv_d        = 1'b0;
    fend_d      = 1'b0;
    fbad_d      = 1'b0;
    plen_d      = plen_q;
    drop_evt    = 1'b0;
    rx_tready   = 1'b1;
    brx_wr_en   = 1'b0;
    brx_wr_data = rx_tdata;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          dst_d  = {dst_q[39:0], rx_tdata};
          hcnt_d = 4'd1;
          pcnt_d = '0;
          ovf_d  = 1'b0;
          if (rx_tlast) drop_evt = 1'b1;
          else          state_d  = HEADER;
        end
      end
      HEADER: begin
        if (beat) begin
          hcnt_d = hcnt_q + 4'd1;
          if (hcnt_q < 4'd6)       dst_d = {dst_q[39:0], rx_tdata};
          else if (hcnt_q < 4'd12) src_d = {src_q[39:0], rx_tdata};
          else                     lt_d  = {lt_q[7:0], rx_tdata};
          if (hcnt_q == 4'd13) begin
            if (match) begin
              hv_d = 1'b1;
              if (rx_tlast) begin
                fend_d  = 1'b1;
                fbad_d  = rx_tuser;
                plen_d  = '0;
                state_d = IDLE;
              end else begin
                state_d = PAYLOAD;
              end
            end else if (rx_tlast) begin
              drop_evt = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = DROP;
            end
          end else if (rx_tlast) begin
            drop_evt = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      PAYLOAD: begin
        rx_tready = ~brx_full;
        if (beat) begin
          if (pcnt_q == SIZE_C) begin
            // byte SIZE+1 is never written; frame ends bad
            ovf_d = 1'b1;
            if (rx_tlast) begin
              fend_d  = 1'b1;
              fbad_d  = 1'b1;
              plen_d  = pcnt_q;
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            brx_wr_en = 1'b1;
            pcnt_d    = pcnt_q + CW'(1);
            if (rx_tlast) begin
              fend_d  = 1'b1;
              fbad_d  = rx_tuser;
              plen_d  = pcnt_q + CW'(1);
              state_d = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (beat && rx_tlast) begin
          if (ovf_q) begin
            fend_d = 1'b1;
            fbad_d = 1'b1;
            plen_d = pcnt_q;
          end else begin
            drop_evt = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
      ovf_q   <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
      lt_q    <= '0;
      hv_q    <= 1'b0;
      fend_q  <= 1'b0;
      fbad_q  <= 1'b0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
      ovf_q   <= ovf_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      lt_q    <= lt_d;
      hv_q    <= hv_d;
      fend_q  <= fend_d;
      fbad_q  <= fbad_d;
      plen_q  <= plen_d;
    end
  end

  assign rx_dst_mac      = dst_q;
  assign rx_src_mac      = src_q;
  assign rx_len_type     = lt_q;
  assign rx_header_valid = hv_q;
  assign brx_frame_end   = fend_q;
  assign brx_frame_bad   = fbad_q;
  assign payload_len     = plen_q;

`ifdef RX_STATS_EN
  logic [15:0] good_q, drop_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      if (fend_q && !fbad_q && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (fend_q && fbad_q && err_q != 16'hFFFF)   err_q  <= err_q + 16'd1;
      if (drop_evt && drop_q != 16'hFFFF)          drop_q <= drop_q + 16'd1;
    end
  end

  assign stat_good = good_q;
  assign stat_drop = drop_q;
  assign stat_err  = err_q;
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser (default and SIZE=16 instances).
module tb_rx_frame_parser;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BMAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] XMAC = 48'h02_00_00_00_00_99;
  localparam logic [47:0] SMAC = 48'h0A_0B_0C_0D_0E_0F;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  rx_tdata = 0;
  logic        rx_tvalid = 0;
  logic        rx_tlast = 0;
  logic        rx_tuser = 0;
  logic        brx_full = 0;
  logic        rx_tready, brx_wr_en, brx_frame_end, brx_frame_bad;
  logic [7:0]  brx_wr_data;
  logic [47:0] rx_dst_mac, rx_src_mac;
  logic [15:0] rx_len_type;
  logic        rx_header_valid;
  logic [11:0] payload_len;

  logic        s_tready, s_wr_en, s_fend, s_fbad, s_hv;
  logic [7:0]  s_wr_data;
  logic [47:0] s_dst, s_src;
  logic [15:0] s_lt;
  logic [4:0]  s_plen;
`ifdef RX_STATS_EN
  logic [15:0] st_good, st_drop, st_err;
  logic [15:0] s_good, s_drop, s_err;
`endif

  always #5 clk = ~clk;

  rx_frame_parser dut (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .rx_tready(rx_tready), .brx_full(brx_full),
    .brx_wr_en(brx_wr_en), .brx_wr_data(brx_wr_data),
    .brx_frame_end(brx_frame_end), .brx_frame_bad(brx_frame_bad),
    .rx_dst_mac(rx_dst_mac), .rx_src_mac(rx_src_mac),
    .rx_len_type(rx_len_type), .rx_header_valid(rx_header_valid),
    .payload_len(payload_len)
`ifdef RX_STATS_EN
    , .stat_good(st_good), .stat_drop(st_drop), .stat_err(st_err)
`endif
  );

  rx_frame_parser #(.SIZE(16)) u_small (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .rx_tready(s_tready), .brx_full(brx_full),
    .brx_wr_en(s_wr_en), .brx_wr_data(s_wr_data),
    .brx_frame_end(s_fend), .brx_frame_bad(s_fbad),
    .rx_dst_mac(s_dst), .rx_src_mac(s_src),
    .rx_len_type(s_lt), .rx_header_valid(s_hv),
    .payload_len(s_plen)
`ifdef RX_STATS_EN
    , .stat_good(s_good), .stat_drop(s_drop), .stat_err(s_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  wq[$];
  int          hv_cnt, fe_cnt, rdy_low;
  logic        fe_bad;
  logic [11:0] fe_len;
  int          s_wcnt, s_fe_cnt;
  logic        s_bad;
  logic [4:0]  s_len;

  always @(negedge clk) begin
    if (brx_wr_en) wq.push_back(brx_wr_data);
    if (rx_header_valid) hv_cnt++;
    if (brx_frame_end) begin
      fe_cnt++;
      fe_bad = brx_frame_bad;
      fe_len = payload_len;
    end
    if (rx_tvalid && !rx_tready) rdy_low++;
    if (s_wr_en) s_wcnt++;
    if (s_fend) begin
      s_fe_cnt++;
      s_bad = s_fbad;
      s_len = s_plen;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    hv_cnt = 0; fe_cnt = 0; rdy_low = 0;
    fe_bad = 0; fe_len = 0;
    s_wcnt = 0; s_fe_cnt = 0; s_bad = 0; s_len = 0;
  endtask

  task automatic beat(input logic [7:0] d, input bit l, input bit u);
    int n = 0;
    rx_tdata = d; rx_tlast = l; rx_tuser = u; rx_tvalid = 1;
    forever begin
      @(negedge clk);
      if (rx_tready) break;
      n++;
      if (n > 200) begin
        chk("beat_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] lt,
                            input int n, input logic [7:0] st,
                            input bit usr, input int full_at);
    logic [111:0] hdr;
    hdr = {dst, SMAC, lt};
    for (int i = 0; i < 14; i++)
      beat(hdr[111-8*i -: 8], (n == 0 && i == 13), usr);
    for (int i = 0; i < n; i++) begin
      if (i == full_at) begin
        brx_full = 1;
        rx_tdata = st + 8'(i); rx_tvalid = 1;
        repeat (5) begin
          @(negedge clk);
          chk("stall_rdy", rx_tready, 0);
        end
        @(posedge clk); #1;
        brx_full = 0;
      end
      beat(st + 8'(i), i == n - 1, usr);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input int n,
                           input logic [7:0] st, input bit bad);
    int err = 0;
    chk({tag, "_hv"}, hv_cnt, 1);
    chk({tag, "_nwr"}, wq.size(), n);
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== st + 8'(i)) err++;
    chk({tag, "_data"}, err, 0);
    chk({tag, "_fe"}, fe_cnt, 1);
    chk({tag, "_bad"}, fe_bad, bad);
    chk({tag, "_len"}, fe_len, n);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fe", brx_frame_end, 0);
    chk("rst_hv", rx_header_valid, 0);
    chk("rst_len", payload_len, 0);
    chk("rst_dst", rx_dst_mac, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_rdy", rx_tready, 1);

    clr();
    send_frame(LMAC, 16'h002E, 46, 8'h00, 0, -1);
    chk_frame("uni", 46, 8'h00, 0);
    chk("uni_dst", rx_dst_mac, LMAC);
    chk("uni_src", rx_src_mac, SMAC);
    chk("uni_lt", rx_len_type, 16'h002E);

    clr();
    send_frame(BMAC, 16'h003C, 60, 8'h10, 1, -1);
    chk_frame("bcast", 60, 8'h10, 1);

    clr();
    send_frame(XMAC, 16'h0014, 20, 8'h30, 0, -1);
    chk("mis_hv", hv_cnt, 0);
    chk("mis_nwr", wq.size(), 0);
    chk("mis_fe", fe_cnt, 0);
    chk("mis_rdy", rdy_low, 0);
    chk("mis_dst", rx_dst_mac, XMAC);

    clr();
    send_frame(LMAC, 16'h000C, 12, 8'hA0, 0, -1);
    chk_frame("aftmis", 12, 8'hA0, 0);

    clr();
    for (int i = 0; i < 10; i++)
      beat(8'h02 + 8'(i), i == 9, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("runt_hv", hv_cnt, 0);
    chk("runt_fe", fe_cnt, 0);
    chk("runt_nwr", wq.size(), 0);

    clr();
    send_frame(LMAC, 16'h0014, 20, 8'h40, 0, -1);
    chk_frame("aftrunt", 20, 8'h40, 0);
    chk("small_nwr", s_wcnt, 16);
    chk("small_fe", s_fe_cnt, 1);
    chk("small_bad", s_bad, 1);
    chk("small_len", s_len, 16);

    clr();
    send_frame(LMAC, 16'h0000, 0, 8'h00, 0, -1);
    chk_frame("zero", 0, 8'h00, 0);

    clr();
    send_frame(LMAC, 16'h000C, 12, 8'hC0, 0, 8);
    chk_frame("full", 12, 8'hC0, 0);
    chk("full_rdylow", rdy_low, 5);

`ifdef RX_STATS_EN
    chk("stat_good", st_good, 5);
    chk("stat_drop", st_drop, 2);
    chk("stat_err", st_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
